// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the raster coordinate type.
// Defaults describe standard 640x480 @ 60 Hz timing.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/sync bundle from the timing generator to the colour mapper and VGA pins.
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic   pixel_clk;
   coord_t DrawX;
   coord_t DrawY;
   logic   blank;
   logic   hs;
   logic   vs;
   logic   sync;
   logic   vblank_tick;

   modport master (output pixel_clk, DrawX, DrawY, blank, hs, vs, sync, vblank_tick);
   modport slave  (input  pixel_clk, DrawX, DrawY, blank, hs, vs, sync, vblank_tick);

endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MODULUS up-counter with enable, synchronous reset and a wrap carry.
// next_o exposes the value the counter will hold after this edge.
module mod_counter
   import vga_pkg::*;
#(
   parameter int MODULUS = 800,
   parameter int WIDTH   = $bits(coord_t)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] next_o,
   output logic             carry_o
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign next_o  = count_d;
   assign carry_o = en_i && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel clock divider, DrawX/DrawY counters,
// zero-skew hs/vs/blank registers and a once-per-frame vblank strobe.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FP      = vga_pkg::H_FP,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BP      = vga_pkg::H_BP,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FP      = vga_pkg::V_FP,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BP      = vga_pkg::V_BP
) (
   input  logic             Clk,
   input  logic             Reset,
   vga_timing_gen_if.master vga
);
   import vga_pkg::*;

   localparam int hTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int vTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int divW   = $clog2(CLK_DIV);

   localparam logic [divW-1:0] divLast  = divW'(CLK_DIV - 1);
   localparam logic [divW-1:0] pclkHigh = divW'(CLK_DIV / 2);

   localparam coord_t hVis    = coord_t'(H_VISIBLE);
   localparam coord_t vVis    = coord_t'(V_VISIBLE);
   localparam coord_t hsStart = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t hsEnd   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t vsStart = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t vsEnd   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   logic [divW-1:0] divCnt_q, divCnt_d;
   logic            pixEn, hCarry, vWrap_unused;
   coord_t          hc, vc, hNext, vNext;
   logic            pixelClk_q, pixelClk_d;
   logic            hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic            vblankTick_q, vblankTick_d;

   always_comb begin
      divCnt_d = (divCnt_q == divLast) ? '0 : divCnt_q + 1'b1;
   end

   assign pixEn = (divCnt_q == divLast);

   mod_counter #(.MODULUS(hTotal)) uHCount (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .en_i    (pixEn),
      .count_o (hc),
      .next_o  (hNext),
      .carry_o (hCarry)
   );

   mod_counter #(.MODULUS(vTotal)) uVCount (
      .clk_i   (Clk),
      .rst_i   (Reset),
      .en_i    (pixEn & hCarry),
      .count_o (vc),
      .next_o  (vNext),
      .carry_o (vWrap_unused)
   );

   // Decode from the next counter values so the registered flags line up with DrawX/DrawY.
   always_comb begin
      pixelClk_d   = (divCnt_d >= pclkHigh);
      hs_d         = !((hNext >= hsStart) && (hNext < hsEnd));
      vs_d         = !((vNext >= vsStart) && (vNext < vsEnd));
      blank_d      = (hNext < hVis) && (vNext < vVis);
      vblankTick_d = hCarry && (vNext == vVis);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         divCnt_q     <= '0;
         pixelClk_q   <= 1'b0;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         blank_q      <= 1'b1;
         vblankTick_q <= 1'b0;
      end else begin
         divCnt_q     <= divCnt_d;
         pixelClk_q   <= pixelClk_d;
         vblankTick_q <= vblankTick_d;
         if (pixEn) begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
         end
      end
   end

   assign vga.pixel_clk   = pixelClk_q;
   assign vga.DrawX       = hc;
   assign vga.DrawY       = vc;
   assign vga.blank       = blank_q;
   assign vga.hs          = hs_q;
   assign vga.vs          = vs_q;
   assign vga.sync        = 1'b0;
   assign vga.vblank_tick = vblankTick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line-level timing and a
// shrunken-timing instance for frame-level behaviour, both scored against a model.
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct packed {
      logic   pclk;
      coord_t x;
      coord_t y;
      logic   blank;
      logic   hs;
      logic   vs;
      logic   sync;
      logic   tick;
   } obs_t;

   typedef struct {
      int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp, cd;
   } cfg_t;

   typedef struct {
      int div;
      int hc;
      int vc;
      bit tick;
   } mstate_t;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   always #5 Clk = ~Clk;

   vga_timing_gen_if ifD ();
   vga_timing_gen_if ifS ();

   vga_timing_gen dutD (
      .Clk   (Clk),
      .Reset (Reset),
      .vga   (ifD.master)
   );

   // Small frame: 25 x 19 pixels, so a frame is 950 Clk.
   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dutS (
      .Clk   (Clk),
      .Reset (Reset),
      .vga   (ifS.master)
   );

   cfg_t    cfgD = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
   cfg_t    cfgS = '{16, 2, 4, 3, 12, 2, 2, 3, 2};
   mstate_t mD, mS;
   obs_t    sbD[$], sbS[$];
   obs_t    obsD, obsS, prevD, prevS, wrapObs;
   obs_t    resetObs;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int phase  = 0;

   int firstX1D = -1, firstX1S = -1;
   int blankFallX = -1, blankFallPrevX = -1;
   int lineWrapCyc = -1, lineWrapX = -1;
   int hsLowClk = 0, hsFirst = -1, hsLast = -1;
   int vsLowClk = 0;
   int wrapSeen = 0, wrapCyc = -1;
   int invBad = 0, syncBad = 0;
   int ticks1[$], ticks3[$], tickX[$], tickY[$];

   function automatic mstate_t stepModel(input cfg_t c, input mstate_t s, input logic rst);
      mstate_t n;
      int ht, vt;
      ht = c.hv + c.hfp + c.hsw + c.hbp;
      vt = c.vv + c.vfp + c.vsw + c.vbp;
      n = s;
      n.tick = 1'b0;
      if (rst) begin
         n.div = 0;
         n.hc  = 0;
         n.vc  = 0;
      end else if (s.div == c.cd - 1) begin
         n.div = 0;
         if (s.hc == ht - 1) begin
            n.hc   = 0;
            n.vc   = (s.vc == vt - 1) ? 0 : s.vc + 1;
            n.tick = (n.vc == c.vv);
         end else begin
            n.hc = s.hc + 1;
         end
      end else begin
         n.div = s.div + 1;
      end
      return n;
   endfunction

   function automatic obs_t expOf(input cfg_t c, input mstate_t s);
      obs_t o;
      o.pclk  = (s.div >= c.cd / 2);
      o.x     = coord_t'(s.hc);
      o.y     = coord_t'(s.vc);
      o.blank = (s.hc < c.hv) && (s.vc < c.vv);
      o.hs    = !((s.hc >= c.hv + c.hfp) && (s.hc < c.hv + c.hfp + c.hsw));
      o.vs    = !((s.vc >= c.vv + c.vfp) && (s.vc < c.vv + c.vfp + c.vsw));
      o.sync  = 1'b0;
      o.tick  = s.tick;
      return o;
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      obs_t expD, expS;
      obsD = {ifD.pixel_clk, ifD.DrawX, ifD.DrawY, ifD.blank, ifD.hs, ifD.vs, ifD.sync, ifD.vblank_tick};
      obsS = {ifS.pixel_clk, ifS.DrawX, ifS.DrawY, ifS.blank, ifS.hs, ifS.vs, ifS.sync, ifS.vblank_tick};
      expD = sbD.pop_front();
      expS = sbS.pop_front();
      checks++;
      assert (obsD === expD)
      else begin
         errors++;
         $error("FAIL dutD raster @cyc %0d: observed %h expected %h", cyc, obsD, expD);
      end
      checks++;
      assert (obsS === expS)
      else begin
         errors++;
         $error("FAIL dutS raster @cyc %0d: observed %h expected %h", cyc, obsS, expS);
      end
   endtask

   // One Clk per iteration: drive Reset off-edge, push the model's prediction at the edge,
   // then pop and compare 1 ns later and update the event trackers.
   task automatic applyStimulus(input logic rstVal, input int n);
      for (int i = 0; i < n; i++) begin
         Reset = rstVal;
         @(posedge Clk);
         mD = stepModel(cfgD, mD, rstVal);
         mS = stepModel(cfgS, mS, rstVal);
         sbD.push_back(expOf(cfgD, mD));
         sbS.push_back(expOf(cfgS, mS));
         #1;
         if (rstVal) cyc = 0;
         else        cyc++;
         checkOutput();
         if (!rstVal && phase == 1) begin
            if (firstX1D < 0 && obsD.x == 1) firstX1D = cyc;
            if (blankFallX < 0 && prevD.blank && !obsD.blank) begin
               blankFallX     = int'(obsD.x);
               blankFallPrevX = int'(prevD.x);
            end
            if (lineWrapCyc < 0 && obsD.y == 1) begin
               lineWrapCyc = cyc;
               lineWrapX   = int'(obsD.x);
            end
            if (obsD.y == 0 && !obsD.hs) begin
               hsLowClk++;
               if (hsFirst < 0) hsFirst = int'(obsD.x);
               hsLast = int'(obsD.x);
            end
            if (cyc <= 950 && !obsS.vs) vsLowClk++;
            if (obsS.tick) begin
               ticks1.push_back(cyc);
               tickX.push_back(int'(obsS.x));
               tickY.push_back(int'(obsS.y));
            end
            if (wrapSeen == 0 && prevS.x == 24 && prevS.y == 18 && obsS.x != 24) begin
               wrapSeen = 1;
               wrapCyc  = cyc;
               wrapObs  = obsS;
            end
         end
         if (!rstVal && phase == 3) begin
            if (firstX1S < 0 && obsS.x == 1) firstX1S = cyc;
            if (obsS.tick) ticks3.push_back(cyc);
            if (obsS.blank !== ((obsS.x < 16) && (obsS.y < 12))) invBad++;
            if (obsS.sync !== 1'b0 || obsD.sync !== 1'b0) syncBad++;
         end
         prevD = obsD;
         prevS = obsS;
      end
   endtask

   initial begin
      int found;
      resetObs = '{pclk: 1'b0, x: '0, y: '0, blank: 1'b1, hs: 1'b1, vs: 1'b1, sync: 1'b0, tick: 1'b0};
      mD = '{0, 0, 0, 1'b0};
      mS = '{0, 0, 0, 1'b0};

      // Cold reset, then line-level and first-frame behaviour.
      phase = 1;
      applyStimulus(1'b1, 3);
      checkEq("dutD reset state", 32'(obsD), 32'(resetObs));
      checkEq("dutS reset state", 32'(obsS), 32'(resetObs));
      applyStimulus(1'b0, 2000);

      checkEq("first DrawX=1 cycle", firstX1D, 2);
      checkEq("blank fall DrawX", blankFallX, 640);
      checkEq("blank fall prev DrawX", blankFallPrevX, 639);
      checkEq("hs low Clk count", hsLowClk, 192);
      checkEq("hs low first DrawX", hsFirst, 656);
      checkEq("hs low last DrawX", hsLast, 751);
      checkEq("line wrap cycle", lineWrapCyc, 1600);
      checkEq("line wrap DrawX", lineWrapX, 0);
      checkEq("small vs low Clk count", vsLowClk, 100);
      checkEq("small tick count first run", ticks1.size(), 2);
      if (ticks1.size() >= 2) begin
         checkEq("small first tick cycle", ticks1[0], 600);
         checkEq("small tick period", ticks1[1] - ticks1[0], 950);
         checkEq("small tick DrawX", tickX[0], 0);
         checkEq("small tick DrawY", tickY[0], 12);
      end
      checkEq("frame wrap seen", wrapSeen, 1);
      checkEq("frame wrap cycle", wrapCyc, 950);
      checkEq("frame wrap DrawX", int'(wrapObs.x), 0);
      checkEq("frame wrap DrawY", int'(wrapObs.y), 0);
      checkEq("frame wrap flags", {wrapObs.blank, wrapObs.hs, wrapObs.vs}, 3'b111);

      // Mid-frame reset in the back porch of a visible line.
      phase = 2;
      found = 0;
      for (int k = 0; k < 2000 && found == 0; k++) begin
         applyStimulus(1'b0, 1);
         if (obsS.x == 23 && obsS.y == 8) found = 1;
      end
      checkEq("reach (23,8) before reset", found, 1);
      checkEq("hs high before mid reset", obsS.hs, 1'b1);
      applyStimulus(1'b1, 1);
      checkEq("dutS mid-frame reset state", 32'(obsS), 32'(resetObs));
      checkEq("dutD mid-frame reset state", 32'(obsD), 32'(resetObs));

      // Two full small frames after the warm reset.
      phase = 3;
      applyStimulus(1'b0, 1900);
      checkEq("warm first DrawX=1 cycle", firstX1S, 2);
      checkEq("warm tick count 2 frames", ticks3.size(), 2);
      if (ticks3.size() >= 1) checkEq("warm first tick cycle", ticks3[0], 600);
      checkEq("blank invariant violations", invBad, 0);
      checkEq("sync nonzero cycles", syncBad, 0);
      checkEq("scoreboard drained", sbD.size() + sbS.size(), 0);

      $display("[TB] directed sequence complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
